// File: rtl/sw_debounce.sv
// Slide-switch conditioner: per-bit multi-flop synchroniser followed by a
// stability counter; emits clean levels plus registered 1-cycle edge pulses.
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             CHANGED
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;
  logic [WIDTH-1:0]                  accept;

  // Stage 0 is the only flop that sees the asynchronous switch; later stages
  // give metastability time to resolve before the counters look at the level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= SW;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          differ;

    assign differ    = s[i] ^ SW_DB[i];
    assign accept[i] = differ && (cnt_q == LAST);

    // Any agreement with the accepted level restarts the count, so a bounce
    // must be followed by a full quiet window; saturating at LAST avoids wrap.
    always_comb begin
      cnt_d = '0;
      if (differ && (cnt_q != LAST)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Levels and pulses update on the same edge so a pulse always coincides
  // with the first cycle of the new SW_DB value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SW_DB   <= '0;
      SW_RISE <= '0;
      SW_FALL <= '0;
      CHANGED <= 1'b0;
    end else begin
      SW_DB   <= SW_DB ^ accept;
      SW_RISE <= accept & s;
      SW_FALL <= accept & ~s;
      CHANGED <= |accept;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed self-checking bench for sw_debounce with a short stability window
// (STABLE_CYCLES=4, SYNC_STAGES=2), so an accepted step lands on the 6th edge.
module tb_sw_debounce;

  logic       CLK;
  logic       RST;
  logic [7:0] SW;
  logic [7:0] SW_DB;
  logic [7:0] SW_RISE;
  logic [7:0] SW_FALL;
  logic       CHANGED;

  int checks   = 0;
  int failures = 0;

  sw_debounce #(.WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SW     (SW),
    .SW_DB  (SW_DB),
    .SW_RISE(SW_RISE),
    .SW_FALL(SW_FALL),
    .CHANGED(CHANGED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge and settle; inputs are driven right after this.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle_to(input logic [7:0] v);
    SW = v;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    SW  = 8'hFF;
    #1;
    checks++;
    if ({SW_DB, SW_RISE, SW_FALL, CHANGED} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL reset_async got db=%h rise=%h fall=%h chg=%b exp all 0", SW_DB, SW_RISE, SW_FALL, CHANGED);
    end
    repeat (3) tick();
    checks++;
    if ({SW_DB, SW_RISE, SW_FALL, CHANGED} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold got db=%h rise=%h fall=%h chg=%b exp all 0", SW_DB, SW_RISE, SW_FALL, CHANGED);
    end
    RST = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (SW_DB !== 8'h00 || SW_RISE !== 8'h00 || CHANGED !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_early edge=%0d got db=%h rise=%h chg=%b exp 00/00/0", k, SW_DB, SW_RISE, CHANGED);
      end
    end
    tick();
    checks++;
    if (SW_DB !== 8'hFF || SW_RISE !== 8'hFF || SW_FALL !== 8'h00 || CHANGED !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_accept got db=%h rise=%h fall=%h chg=%b exp FF/FF/00/1", SW_DB, SW_RISE, SW_FALL, CHANGED);
    end
    tick();
    checks++;
    if (SW_DB !== 8'hFF || SW_RISE !== 8'h00 || CHANGED !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_pulse_end got db=%h rise=%h chg=%b exp FF/00/0", SW_DB, SW_RISE, CHANGED);
    end
  endtask

  task automatic test_clean_step();
    settle_to(8'h00);
    checks++;
    if (SW_DB !== 8'h00) begin
      failures++;
      $display("[TB] FAIL step_settle got db=%h exp 00", SW_DB);
    end
    SW = 8'h5A;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (SW_DB !== 8'h00 || SW_RISE !== 8'h00) begin
        failures++;
        $display("[TB] FAIL step_rise_early edge=%0d got db=%h rise=%h exp 00/00", k, SW_DB, SW_RISE);
      end
    end
    tick();
    checks++;
    if (SW_DB !== 8'h5A || SW_RISE !== 8'h5A || SW_FALL !== 8'h00 || CHANGED !== 1'b1) begin
      failures++;
      $display("[TB] FAIL step_rise got db=%h rise=%h fall=%h chg=%b exp 5A/5A/00/1", SW_DB, SW_RISE, SW_FALL, CHANGED);
    end
    tick();
    checks++;
    if (SW_RISE !== 8'h00 || CHANGED !== 1'b0) begin
      failures++;
      $display("[TB] FAIL step_rise_end got rise=%h chg=%b exp 00/0", SW_RISE, CHANGED);
    end
    SW = 8'h00;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (SW_DB !== 8'h5A || SW_FALL !== 8'h00) begin
        failures++;
        $display("[TB] FAIL step_fall_early edge=%0d got db=%h fall=%h exp 5A/00", k, SW_DB, SW_FALL);
      end
    end
    tick();
    checks++;
    if (SW_DB !== 8'h00 || SW_FALL !== 8'h5A || SW_RISE !== 8'h00 || CHANGED !== 1'b1) begin
      failures++;
      $display("[TB] FAIL step_fall got db=%h fall=%h rise=%h chg=%b exp 00/5A/00/1", SW_DB, SW_FALL, SW_RISE, CHANGED);
    end
    tick();
    checks++;
    if (SW_FALL !== 8'h00 || CHANGED !== 1'b0) begin
      failures++;
      $display("[TB] FAIL step_fall_end got fall=%h chg=%b exp 00/0", SW_FALL, CHANGED);
    end
  endtask

  task automatic test_mixed_edges();
    settle_to(8'h0F);
    SW = 8'hF0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (CHANGED !== 1'b0 || SW_DB !== 8'h0F) begin
        failures++;
        $display("[TB] FAIL mixed_early edge=%0d got db=%h chg=%b exp 0F/0", k, SW_DB, CHANGED);
      end
    end
    tick();
    checks++;
    if (SW_DB !== 8'hF0 || SW_RISE !== 8'hF0 || SW_FALL !== 8'h0F || CHANGED !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mixed_accept got db=%h rise=%h fall=%h chg=%b exp F0/F0/0F/1", SW_DB, SW_RISE, SW_FALL, CHANGED);
    end
    tick();
    checks++;
    if (CHANGED !== 1'b0 || SW_RISE !== 8'h00 || SW_FALL !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mixed_end got rise=%h fall=%h chg=%b exp 00/00/0", SW_RISE, SW_FALL, CHANGED);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pattern [4];
    pattern[0] = 8'h01;
    pattern[1] = 8'h00;
    pattern[2] = 8'h01;
    pattern[3] = 8'h00;
    settle_to(8'h00);
    for (int k = 0; k < 4; k++) begin
      SW = pattern[k];
      tick();
      checks++;
      if (SW_DB !== 8'h00 || CHANGED !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bounce_phase idx=%0d got db=%h chg=%b exp 00/0", k, SW_DB, CHANGED);
      end
    end
    SW = 8'h01;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (SW_DB !== 8'h00 || SW_RISE !== 8'h00) begin
        failures++;
        $display("[TB] FAIL bounce_early edge=%0d got db=%h rise=%h exp 00/00", k, SW_DB, SW_RISE);
      end
    end
    tick();
    checks++;
    if (SW_DB !== 8'h01 || SW_RISE !== 8'h01 || CHANGED !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bounce_accept got db=%h rise=%h chg=%b exp 01/01/1", SW_DB, SW_RISE, CHANGED);
    end
  endtask

  task automatic test_short_pulse();
    SW = 8'h09;
    repeat (3) tick();
    SW = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (SW_DB !== 8'h01 || SW_RISE !== 8'h00 || CHANGED !== 1'b0) begin
        failures++;
        $display("[TB] FAIL short_pulse edge=%0d got db=%h rise=%h chg=%b exp 01/00/0", k, SW_DB, SW_RISE, CHANGED);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    SW = 8'h81;
    repeat (4) tick();
    RST = 1'b1;
    #1;
    checks++;
    if ({SW_DB, SW_RISE, SW_FALL, CHANGED} !== 25'd0) begin
      failures++;
      $display("[TB] FAIL midreset_async got db=%h rise=%h fall=%h chg=%b exp all 0", SW_DB, SW_RISE, SW_FALL, CHANGED);
    end
    repeat (3) tick();
    RST = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (SW_DB !== 8'h00 || SW_RISE !== 8'h00) begin
        failures++;
        $display("[TB] FAIL midreset_early edge=%0d got db=%h rise=%h exp 00/00", k, SW_DB, SW_RISE);
      end
    end
    tick();
    checks++;
    if (SW_DB !== 8'h81 || SW_RISE !== 8'h81 || CHANGED !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_accept got db=%h rise=%h chg=%b exp 81/81/1", SW_DB, SW_RISE, CHANGED);
    end
  endtask

  task automatic test_sweep();
    int sweep_errors;
    sweep_errors = 0;
    for (int v = 0; v < 256; v++) begin
      SW = 8'(v);
      repeat (10) tick();
      checks++;
      if (SW_DB !== 8'(v)) begin
        failures++;
        sweep_errors++;
        $display("[TB] FAIL sweep value=%h got db=%h exp %h", 8'(v), SW_DB, 8'(v));
      end
    end
    $display("[TB] sweep done, errors=%0d", sweep_errors);
  endtask

  initial begin
    RST = 1'b1;
    SW  = 8'h00;
    tick();
    test_reset();
    test_clean_step();
    test_mixed_edges();
    test_bounce();
    test_short_pulse();
    test_reset_mid_count();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
